// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-in strobe and show-ahead byte-out stream plus FIFO status
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int ERRW  = 8
);
  logic [7:0]                   in_data;
  logic                         in_valid;
  logic                         in_parity_ok;
  logic                         clr;
  logic [7:0]                   out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         full;
  logic                         overflow;
  logic [ERRW-1:0]              par_err_cnt;
  modport master (
    output in_data, in_valid, in_parity_ok, clr, out_ready,
    input  out_data, out_valid, level, full, overflow, par_err_cnt
  );
  modport slave (
    input  in_data, in_valid, in_parity_ok, clr, out_ready,
    output out_data, out_valid, level, full, overflow, par_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO behind a UART receiver with parity filtering,
// sticky overflow flag and saturating parity-error counter.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter bit DROP_BAD_PAR = 1'b1,
  parameter int ERRW         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [ERRW-1:0] par_err_q, par_err_d;
  logic            good, bad, rd_en, wr_en, lost;
  // status outputs depend only on registers, never on same-cycle inputs
  assign bus.out_valid   = |level_q;
  assign bus.full        = level_q == LW'(DEPTH);
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.par_err_cnt = par_err_q;
  assign bus.out_data    = bus.out_valid ? mem_q[rd_ptr_q] : 8'h00;
  always_comb begin
    good       = bus.in_valid & (bus.in_parity_ok | !DROP_BAD_PAR);
    bad        = bus.in_valid & !bus.in_parity_ok;
    rd_en      = bus.out_valid & bus.out_ready;
    wr_en      = good & (!bus.full | rd_en);
    lost       = good & bus.full & !rd_en;
    wr_ptr_d   = bus.clr ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = bus.clr ? '0 : rd_ptr_q + AW'(rd_en);
    level_d    = bus.clr ? '0 : level_q + LW'(wr_en) - LW'(rd_en);
    overflow_d = !bus.clr & (overflow_q | lost);
    par_err_d  = bus.clr ? '0 : par_err_q + ERRW'(bad & ~&par_err_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      par_err_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      par_err_q  <= par_err_d;
    end
  always_ff @(posedge clk)
    if (wr_en && !bus.clr) mem_q[wr_ptr_q] <= bus.in_data;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the UART byte FIFO; dut_b is the keep-bad-parity build.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  uart_rx_fifo_if #(.DEPTH(16), .ERRW(8)) a ();
  uart_rx_fifo_if #(.DEPTH(16), .ERRW(8)) b ();
  assign b.in_data      = a.in_data;
  assign b.in_valid     = a.in_valid;
  assign b.in_parity_ok = a.in_parity_ok;
  assign b.clr          = a.clr;
  assign b.out_ready    = a.out_ready;
  uart_rx_fifo #(.DEPTH(16), .DROP_BAD_PAR(1'b1), .ERRW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  uart_rx_fifo #(.DEPTH(16), .DROP_BAD_PAR(1'b0), .ERRW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic p);
    a.in_data = d;
    a.in_parity_ok = p;
    a.in_valid = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
  endtask
  task automatic pulse_clr();
    a.clr = 1'b1;
    @(negedge clk);
    a.clr = 1'b0;
  endtask
  logic [7:0] ord [4] = '{8'h36, 8'h32, 8'h38, 8'h34};
  initial begin
    a.in_data = 8'h00;
    a.in_valid = 1'b0;
    a.in_parity_ok = 1'b1;
    a.clr = 1'b0;
    a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a.in_valid = i[0];
      a.in_parity_ok = i[1];
      a.in_data = 8'(i * 17);
      a.out_ready = ~i[0];
    end
    @(negedge clk);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_level", a.level, 0);
    chk("rst_overflow", a.overflow, 0);
    chk("rst_par_err", a.par_err_cnt, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_full", a.full, 0);
    a.in_valid = 1'b0;
    a.in_parity_ok = 1'b1;
    a.out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h36, 1'b1);
    chk("latency_out_valid", a.out_valid, 1);
    chk("latency_head", a.out_data, 8'h36);
    for (int i = 1; i < 4; i++) push(ord[i], 1'b1);
    chk("order_level", a.level, 4);
    chk("order_head_stable", a.out_data, 8'h36);
    a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_pop", a.out_data, ord[i]);
      @(negedge clk);
    end
    chk("order_level_end", a.level, 0);
    @(negedge clk);
    chk("underflow_level", a.level, 0);
    chk("underflow_valid", a.out_valid, 0);
    a.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) push(8'(i), 1'b1);
    chk("ovf_full", a.full, 1);
    chk("ovf_level", a.level, 16);
    chk("ovf_flag", a.overflow, 1);
    a.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_pop", a.out_data, 32'(i));
      @(negedge clk);
    end
    chk("ovf_drained", a.out_valid, 0);
    chk("ovf_sticky", a.overflow, 1);
    a.out_ready = 1'b0;
    pulse_clr();
    chk("clr_overflow", a.overflow, 0);
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
    chk("rw_full_pre", a.full, 1);
    a.out_ready = 1'b1;
    push(8'hAA, 1'b1);
    chk("rw_level", a.level, 16);
    chk("rw_overflow", a.overflow, 0);
    for (int i = 1; i < 16; i++) begin
      chk("rw_pop", a.out_data, 32'(8'h20 + i));
      @(negedge clk);
    end
    chk("rw_last", a.out_data, 8'hAA);
    @(negedge clk);
    chk("rw_empty", a.level, 0);
    a.out_ready = 1'b0;
    push(8'h41, 1'b1);
    push(8'h42, 1'b0);
    push(8'h43, 1'b1);
    chk("par_level_drop", a.level, 2);
    chk("par_level_keep", b.level, 3);
    chk("par_cnt_drop", a.par_err_cnt, 1);
    chk("par_cnt_keep", b.par_err_cnt, 1);
    a.out_ready = 1'b1;
    chk("par_pop0_drop", a.out_data, 8'h41);
    chk("par_pop0_keep", b.out_data, 8'h41);
    @(negedge clk);
    chk("par_pop1_drop", a.out_data, 8'h43);
    chk("par_pop1_keep", b.out_data, 8'h42);
    @(negedge clk);
    chk("par_pop2_drop_empty", a.out_valid, 0);
    chk("par_pop2_keep", b.out_data, 8'h43);
    @(negedge clk);
    a.out_ready = 1'b0;
    pulse_clr();
    for (int i = 0; i < 17; i++) push(8'(i), 1'b1);
    for (int i = 0; i < 260; i++) push(8'h5A, 1'b0);
    chk("sat_cnt", a.par_err_cnt, 255);
    chk("sat_level", a.level, 16);
    chk("sat_ovf_bad_only", a.overflow, 1);
    pulse_clr();
    for (int i = 0; i < 258; i++) push(8'h5A, 1'b0);
    chk("sat_cnt_drop", a.par_err_cnt, 255);
    chk("sat_no_ovf_drop", a.overflow, 0);
    chk("sat_no_store_drop", a.level, 0);
    chk("sat_ovf_keep", b.overflow, 1);
    pulse_clr();
    chk("clr_par_err", a.par_err_cnt, 0);
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b1);
    chk("clr_pre_level", a.level, 5);
    a.in_data = 8'h55;
    a.in_valid = 1'b1;
    a.clr = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
    a.clr = 1'b0;
    chk("clr_level", a.level, 0);
    chk("clr_ovf", a.overflow, 0);
    @(negedge clk);
    chk("clr_55_absent", a.out_valid, 0);
    for (int i = 0; i < 5; i++) push(8'(8'h70 + i), 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_level", a.level, 0);
    chk("arst_valid", a.out_valid, 0);
    chk("arst_ovf", a.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h77, 1'b1);
    chk("post_rst_level", a.level, 1);
    chk("post_rst_head", a.out_data, 8'h77);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
